// File: rtl/dac_frame_scheduler.sv
// Round-robin sharing of one serial DAC: one DW-bit frame per PERIOD-cycle slot, MSB first on sdi.
// Frame starts the cycle after slot start; req_ready is a combinational one-cycle accept at slot start.
module dac_frame_scheduler #(
    parameter int DW        = 16,
    parameter int NREQ      = 4,
    parameter int PERIOD    = 24,
    parameter int HOLD_LAST = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 dac_sclk,
    output logic                 dac_cs_n,
    output logic                 dac_sdi,
    output logic [2:0]           active_id,
    output logic                 frame_done,
    output logic [15:0]          underrun_cnt
);
    localparam int CW = $clog2(PERIOD);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    if (PERIOD < DW + 2) begin : g_bad_period
        $error("dac_frame_scheduler: PERIOD must be at least DW+2");
    end
    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("dac_frame_scheduler: NREQ must be in 1..8");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DW-1:0]   shift_reg;
    logic [DW-1:0]   last_word;
    logic            have_last;
    logic [2:0]      rr_ptr;

    logic [2:0]      ptr_next;
    logic [NREQ-1:0] rot;
    logic [3:0]      off;
    logic [3:0]      sum;
    logic            grant_vld;
    logic [2:0]      grant_id;
    logic [DW-1:0]   grant_word;
    logic            slot_start;
    logic            accept;
    logic            load_go;
    logic [DW-1:0]   load_word;

    assign dac_sclk = ~aclk;

    // Rotate the valid vector so bit 0 is the requester just after the last grant.
    always_comb begin
        ptr_next  = (rr_ptr == 3'(NREQ - 1)) ? 3'd0 : rr_ptr + 3'd1;
        rot       = NREQ'({req_valid, req_valid} >> ptr_next);
        grant_vld = 1'b0;
        off       = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_vld = 1'b1;
                off       = 4'(j);
            end
        end
        sum = {1'b0, ptr_next} + off;
        if (sum >= 4'(NREQ)) begin
            sum = sum - 4'(NREQ);
        end
        grant_id   = sum[2:0];
        grant_word = DW'(req_data >> (32'(grant_id) * DW));

        slot_start = en && !areset && (state == IDLE) && (cnt == '0);
        accept     = slot_start && grant_vld;
        load_go    = slot_start && (grant_vld || (HOLD_LAST != 0 && have_last));
        load_word  = grant_vld ? grant_word : last_word;
        req_ready  = accept ? (NREQ'(1) << grant_id) : '0;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            last_word    <= '0;
            have_last    <= 1'b0;
            rr_ptr       <= '0;
            dac_cs_n     <= 1'b1;
            dac_sdi      <= 1'b0;
            active_id    <= '0;
            frame_done   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            frame_done <= 1'b0;

            if (!en || cnt == CW'(PERIOD - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                last_word <= grant_word;
                have_last <= 1'b1;
                rr_ptr    <= grant_id;
                active_id <= grant_id;
            end

            if (slot_start && !grant_vld && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (load_go) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        dac_cs_n  <= 1'b0;
                        dac_sdi   <= load_word[DW-1];
                        shift_reg <= load_word << 1;
                    end
                end
                SHIFT: begin
                    // The edge closing the last bit cycle releases cs_n and flags the frame end.
                    if (bit_cnt == BW'(DW - 1)) begin
                        state      <= IDLE;
                        dac_cs_n   <= 1'b1;
                        dac_sdi    <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        dac_sdi   <= shift_reg[DW-1];
                        shift_reg <= shift_reg << 1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
